// File: rtl/iob_picorv32_bus_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_picorv32_bus_merge_pkg
// Purpose  : Shared constants for the PicoRV32 ibus/dbus merge stage:
//            FSM state encoding and bus-select encoding.
// Ports    : none (package)
// Options  : IOB_PICORV32_BUS_MERGE_RR_EN (consumed by the arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package iob_picorv32_bus_merge_pkg;

  // Merge FSM states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  // Bus select encoding
  localparam logic SEL_IBUS = 1'b0;
  localparam logic SEL_DBUS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/iob_picorv32_bus_merge_arb.sv
`default_nettype none
// ============================================================================
// Module   : iob_picorv32_bus_merge_arb
// Purpose  : Two-way winner selection between ibus and dbus requests.
//            Default build: fixed priority, dbus wins over ibus.
//            With IOB_PICORV32_BUS_MERGE_RR_EN defined: round-robin on a tie,
//            the bus that did not win last time is granted.
// Ports    : clk_i, rst_i        clock, synchronous active-high reset
//            ibus_avalid_i       instruction request pending
//            dbus_avalid_i       data request pending
//            accept_i            a request was accepted this cycle
//            accept_sel_i        which bus that accepted request belonged to
//            winner_o            selected bus (SEL_IBUS / SEL_DBUS)
// Options  : IOB_PICORV32_BUS_MERGE_RR_EN
// Revision : 1.0 - initial release
// ============================================================================
module iob_picorv32_bus_merge_arb
  import iob_picorv32_bus_merge_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic ibus_avalid_i,
  input  logic dbus_avalid_i,
  input  logic accept_i,
  input  logic accept_sel_i,
  output logic winner_o
);

`ifdef IOB_PICORV32_BUS_MERGE_RR_EN
  logic last_winner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner_q <= SEL_DBUS;
    end else if (accept_i) begin
      last_winner_q <= accept_sel_i;
    end
  end

  always_comb begin
    winner_o = SEL_IBUS;
    if (ibus_avalid_i && dbus_avalid_i) begin
      // tie: hand the grant to the bus that lost last time
      winner_o = ~last_winner_q;
    end else if (dbus_avalid_i) begin
      winner_o = SEL_DBUS;
    end
  end
`else
  // Fixed priority needs no state; the sequential inputs are intentionally idle.
  logic w_unused;
  assign w_unused = ^{clk_i, rst_i, accept_i, accept_sel_i, ibus_avalid_i};

  always_comb begin
    winner_o = dbus_avalid_i ? SEL_DBUS : SEL_IBUS;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/iob_picorv32_bus_merge.sv
`default_nettype none
// ============================================================================
// Module   : iob_picorv32_bus_merge
// Purpose  : Merges the PicoRV32 instruction (ibus) and data (dbus) IOb-native
//            master buses into a single IOb-native master port. Arbitrates in
//            IDLE with zero-cycle forwarding, locks the grant while the slave
//            stalls (HOLD), and tracks one outstanding read (WAIT_R) so that
//            the response is routed back to the bus that issued it.
// Ports    : clk_i, rst_i                      clock, sync active-high reset
//            ibus_avalid/addr/wdata/wstrb_i    instruction request
//            ibus_rdata/rvalid/ready_o         instruction response
//            dbus_avalid/addr/wdata/wstrb_i    data request
//            dbus_rdata/rvalid/ready_o         data response
//            m_avalid/addr/wdata/wstrb_o       merged request
//            m_rdata/rvalid/ready_i            merged response
// Options  : IOB_PICORV32_BUS_MERGE_RR_EN (round-robin arbitration)
// Revision : 1.0 - initial release
// ============================================================================
module iob_picorv32_bus_merge
  import iob_picorv32_bus_merge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // instruction bus
  input  logic                  ibus_avalid_i,
  input  logic [ADDR_W-1:0]     ibus_addr_i,
  input  logic [DATA_W-1:0]     ibus_wdata_i,
  input  logic [DATA_W/8-1:0]   ibus_wstrb_i,
  output logic [DATA_W-1:0]     ibus_rdata_o,
  output logic                  ibus_rvalid_o,
  output logic                  ibus_ready_o,
  // data bus
  input  logic                  dbus_avalid_i,
  input  logic [ADDR_W-1:0]     dbus_addr_i,
  input  logic [DATA_W-1:0]     dbus_wdata_i,
  input  logic [DATA_W/8-1:0]   dbus_wstrb_i,
  output logic [DATA_W-1:0]     dbus_rdata_o,
  output logic                  dbus_rvalid_o,
  output logic                  dbus_ready_o,
  // merged master port
  output logic                  m_avalid_o,
  output logic [ADDR_W-1:0]     m_addr_o,
  output logic [DATA_W-1:0]     m_wdata_o,
  output logic [DATA_W/8-1:0]   m_wstrb_o,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic                  m_rvalid_i,
  input  logic                  m_ready_i
);

  logic [1:0] state_q, state_d;
  logic       sel_q, sel_d;

  logic       w_winner;
  logic       w_cur;       // bus currently owning the request path
  logic       w_req_valid; // owning bus has a request on the merged port
  logic       w_req_wr;    // that request is a write
  logic       w_accept;

  // In IDLE the arbiter picks the owner live; in HOLD the grant is locked.
  assign w_cur       = (state_q == IDLE) ? w_winner : sel_q;
  assign w_req_valid = (state_q != WAIT_R) &&
                       ((w_cur == SEL_DBUS) ? dbus_avalid_i : ibus_avalid_i);
  assign w_req_wr    = (w_cur == SEL_DBUS) ? (|dbus_wstrb_i) : (|ibus_wstrb_i);
  assign w_accept    = w_req_valid && m_ready_i;

  iob_picorv32_bus_merge_arb u_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ibus_avalid_i (ibus_avalid_i),
    .dbus_avalid_i (dbus_avalid_i),
    .accept_i      (w_accept),
    .accept_sel_i  (w_cur),
    .winner_o      (w_winner)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= SEL_IBUS;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (w_req_valid) begin
          sel_d = w_cur;
          if (m_ready_i) begin
            state_d = w_req_wr ? IDLE : WAIT_R;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A granted request withdrawn before acceptance releases the lock.
        if (!w_req_valid) begin
          state_d = IDLE;
        end else if (m_ready_i) begin
          state_d = w_req_wr ? IDLE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    m_avalid_o    = 1'b0;
    m_addr_o      = '0;
    m_wdata_o     = '0;
    m_wstrb_o     = '0;
    ibus_ready_o  = 1'b0;
    dbus_ready_o  = 1'b0;
    ibus_rvalid_o = 1'b0;
    dbus_rvalid_o = 1'b0;
    ibus_rdata_o  = '0;
    dbus_rdata_o  = '0;

    if (w_req_valid) begin
      m_avalid_o = 1'b1;
      if (w_cur == SEL_DBUS) begin
        m_addr_o     = dbus_addr_i;
        m_wdata_o    = dbus_wdata_i;
        m_wstrb_o    = dbus_wstrb_i;
        dbus_ready_o = m_ready_i;
      end else begin
        m_addr_o     = ibus_addr_i;
        m_wdata_o    = ibus_wdata_i;
        m_wstrb_o    = ibus_wstrb_i;
        ibus_ready_o = m_ready_i;
      end
    end

    // Responses are only meaningful while a read is outstanding; an rvalid
    // seen in any other state is a slave error and is swallowed here.
    if (state_q == WAIT_R) begin
      ibus_rdata_o  = m_rdata_i;
      dbus_rdata_o  = m_rdata_i;
      ibus_rvalid_o = m_rvalid_i && (sel_q == SEL_IBUS);
      dbus_rvalid_o = m_rvalid_i && (sel_q == SEL_DBUS);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_picorv32_bus_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_picorv32_bus_merge
// Purpose  : Self-checking bench for iob_picorv32_bus_merge: directed
//            scenarios followed by randomized master/slave traffic compared
//            against a bus-ownership reference model.
// Options  : IOB_PICORV32_BUS_MERGE_RR_EN selects round-robin expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_picorv32_bus_merge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef IOB_PICORV32_BUS_MERGE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ibus_avalid_i, dbus_avalid_i;
  logic [AW-1:0] ibus_addr_i, dbus_addr_i;
  logic [DW-1:0] ibus_wdata_i, dbus_wdata_i;
  logic [SW-1:0] ibus_wstrb_i, dbus_wstrb_i;
  logic [DW-1:0] ibus_rdata_o, dbus_rdata_o;
  logic          ibus_rvalid_o, dbus_rvalid_o, ibus_ready_o, dbus_ready_o;
  logic          m_avalid_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_wstrb_o;
  logic [DW-1:0] m_rdata_i;
  logic          m_rvalid_i, m_ready_i;

  iob_picorv32_bus_merge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ibus_avalid_i(ibus_avalid_i), .ibus_addr_i(ibus_addr_i),
    .ibus_wdata_i(ibus_wdata_i), .ibus_wstrb_i(ibus_wstrb_i),
    .ibus_rdata_o(ibus_rdata_o), .ibus_rvalid_o(ibus_rvalid_o), .ibus_ready_o(ibus_ready_o),
    .dbus_avalid_i(dbus_avalid_i), .dbus_addr_i(dbus_addr_i),
    .dbus_wdata_i(dbus_wdata_i), .dbus_wstrb_i(dbus_wstrb_i),
    .dbus_rdata_o(dbus_rdata_o), .dbus_rvalid_o(dbus_rvalid_o), .dbus_ready_o(dbus_ready_o),
    .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_rdata_i(m_rdata_i), .m_rvalid_i(m_rvalid_i), .m_ready_i(m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clr();
    ibus_avalid_i = 1'b0; ibus_addr_i = '0; ibus_wdata_i = '0; ibus_wstrb_i = '0;
    dbus_avalid_i = 1'b0; dbus_addr_i = '0; dbus_wdata_i = '0; dbus_wstrb_i = '0;
    m_rdata_i = '0; m_rvalid_i = 1'b0; m_ready_i = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // reference model state (bus ids: 0 = ibus, 1 = dbus, -1 = none)
  int            lock, rd, last, g, cnt, w;
  bit            act[2], wt[2], pend;
  logic [AW-1:0] ra[2];
  logic [DW-1:0] rw[2];
  logic [SW-1:0] rs[2];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [SW-1:0] e_wstrb;

  initial begin
    clr();
    rst_i = 1'b1;
    repeat (3) cyc();
    rst_i = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk_i);
    chk("rst m_avalid", m_avalid_o, 0);
    chk("rst m_addr", m_addr_o, 0);
    chk("rst readys", {ibus_ready_o, dbus_ready_o}, 0);
    chk("rst rvalids", {ibus_rvalid_o, dbus_rvalid_o}, 0);
    chk("rst rdata", {ibus_rdata_o, dbus_rdata_o}, 0);
    cyc();

    // ---------------- ibus read, immediate accept ----------------
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h1000_0000; m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t1 ibus_ready", ibus_ready_o, 1);
    chk("t1 dbus_ready", dbus_ready_o, 0);
    chk("t1 m_avalid", m_avalid_o, 1);
    chk("t1 m_addr", m_addr_o, 32'h1000_0000);
    cyc();
    ibus_avalid_i = 1'b0; m_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t1 c1 m_avalid", m_avalid_o, 0);
    chk("t1 c1 rvalids", {ibus_rvalid_o, dbus_rvalid_o}, 0);
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("t1 ibus_rvalid", ibus_rvalid_o, 1);
    chk("t1 ibus_rdata", ibus_rdata_o, 32'hDEAD_BEEF);
    chk("t1 dbus_rvalid", dbus_rvalid_o, 0);
    cyc();
    clr();

    // ---------------- dbus write stalled 3 cycles ----------------
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h20; dbus_wdata_i = 32'h1234_5678; dbus_wstrb_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      m_ready_i = (k == 3);
      @(negedge clk_i);
      chk("t2 m_avalid", m_avalid_o, 1);
      chk("t2 m_addr", m_addr_o, 32'h20);
      chk("t2 m_wdata", m_wdata_o, 32'h1234_5678);
      chk("t2 m_wstrb", m_wstrb_o, 4'hF);
      chk("t2 dbus_ready", dbus_ready_o, (k == 3));
      chk("t2 rvalids", {ibus_rvalid_o, dbus_rvalid_o}, 0);
      cyc();
    end
    clr();
    m_rvalid_i = 1'b1; // no read outstanding: must be dropped
    @(negedge clk_i);
    chk("t2 post m_avalid", m_avalid_o, 0);
    chk("t2 post rvalids", {ibus_rvalid_o, dbus_rvalid_o}, 0);
    cyc();
    clr();
    // back in IDLE: an ibus write is accepted straight away
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h44; ibus_wstrb_i = 4'h1; m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t2 idle ibus_ready", ibus_ready_o, 1);
    cyc();
    clr();

    // ---------------- simultaneous reads, dbus first ----------------
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'hA0;
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'hB0;
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t3 dbus_ready", dbus_ready_o, 1);
    chk("t3 ibus_ready", ibus_ready_o, 0);
    chk("t3 m_addr", m_addr_o, 32'hB0);
    cyc();
    dbus_avalid_i = 1'b0;
    @(negedge clk_i);
    chk("t3 wait ibus_ready", ibus_ready_o, 0);
    chk("t3 wait m_avalid", m_avalid_o, 0);
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hC0;
    @(negedge clk_i);
    chk("t3 dbus_rvalid", dbus_rvalid_o, 1);
    chk("t3 dbus_rdata", dbus_rdata_o, 32'hC0);
    chk("t3 ibus_rvalid", ibus_rvalid_o, 0);
    chk("t3 bubble ibus_ready", ibus_ready_o, 0);
    chk("t3 bubble m_avalid", m_avalid_o, 0);
    cyc();
    m_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t3 ibus_ready", ibus_ready_o, 1);
    chk("t3 ibus m_addr", m_addr_o, 32'hA0);
    cyc();
    ibus_avalid_i = 1'b0; m_ready_i = 1'b0;
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hC1;
    @(negedge clk_i);
    chk("t3 ibus_rvalid", ibus_rvalid_o, 1);
    chk("t3 ibus_rdata", ibus_rdata_o, 32'hC1);
    chk("t3 dbus_rvalid late", dbus_rvalid_o, 0);
    cyc();
    clr();

    // ---------------- 4 back-to-back contended reads ----------------
    // last grant was ibus, so round-robin alternates starting with dbus
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h0A00;
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h0B00;
    for (int k = 0; k < 4; k++) begin
      w = RR ? ((k % 2 == 0) ? 1 : 0) : 1;
      m_ready_i = 1'b1; m_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("t4 ibus_ready", ibus_ready_o, (w == 0));
      chk("t4 dbus_ready", dbus_ready_o, (w == 1));
      chk("t4 m_addr", m_addr_o, (w == 1) ? 32'h0B00 : 32'h0A00);
      cyc();
      m_ready_i = 1'b0;
      @(negedge clk_i);
      chk("t4 wait m_avalid", m_avalid_o, 0);
      cyc();
      m_rvalid_i = 1'b1; m_rdata_i = 32'h100 + k;
      @(negedge clk_i);
      chk("t4 ibus_rvalid", ibus_rvalid_o, (w == 0));
      chk("t4 dbus_rvalid", dbus_rvalid_o, (w == 1));
      cyc();
    end
    clr();

    // ---------------- grant lock in HOLD ----------------
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h40; dbus_wstrb_i = 4'h3;
    @(negedge clk_i);
    chk("t5 m_addr", m_addr_o, 32'h40);
    chk("t5 dbus_ready", dbus_ready_o, 0);
    cyc();
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h80; ibus_wstrb_i = 4'hF;
    repeat (2) begin
      @(negedge clk_i);
      chk("t5 hold ibus_ready", ibus_ready_o, 0);
      chk("t5 hold m_addr", m_addr_o, 32'h40);
      cyc();
    end
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t5 acc dbus_ready", dbus_ready_o, 1);
    chk("t5 acc ibus_ready", ibus_ready_o, 0);
    chk("t5 acc m_addr", m_addr_o, 32'h40);
    cyc();
    dbus_avalid_i = 1'b0;
    @(negedge clk_i);
    chk("t5 next ibus_ready", ibus_ready_o, 1);
    chk("t5 next m_addr", m_addr_o, 32'h80);
    cyc();
    clr();

    // ---------------- reset during WAIT_R ----------------
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h900; m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t6 ibus_ready", ibus_ready_o, 1);
    cyc();
    clr();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    m_rvalid_i = 1'b1; m_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    chk("t6 rvalids", {ibus_rvalid_o, dbus_rvalid_o}, 0);
    chk("t6 m_avalid", m_avalid_o, 0);
    cyc();
    clr();
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h77; dbus_wstrb_i = 4'h8; m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t6 idle dbus_ready", dbus_ready_o, 1);
    cyc();
    clr();

    // ---------------- randomized traffic vs. reference model ----------------
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    lock = -1; rd = -1; last = 1; pend = 1'b0; cnt = 0;
    act[0] = 1'b0; act[1] = 1'b0; wt[0] = 1'b0; wt[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ra[b] = $urandom; rw[b] = $urandom; rs[b] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (!act[b] && !wt[b] && $urandom_range(0, 2) == 0) begin
          act[b] = 1'b1;
          ra[b]  = $urandom;
          rw[b]  = $urandom;
          rs[b]  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        end
      end
      ibus_avalid_i = act[0]; ibus_addr_i = ra[0]; ibus_wdata_i = rw[0]; ibus_wstrb_i = rs[0];
      dbus_avalid_i = act[1]; dbus_addr_i = ra[1]; dbus_wdata_i = rw[1]; dbus_wstrb_i = rs[1];
      m_ready_i = 1'($urandom_range(0, 1));
      m_rdata_i = $urandom;
      if (pend && cnt == 0)  m_rvalid_i = 1'b1;
      else if (!pend)        m_rvalid_i = ($urandom_range(0, 7) == 0);
      else                   m_rvalid_i = 1'b0;

      @(negedge clk_i);
      // who owns the merged port this cycle
      if (rd >= 0)                 g = -1;
      else if (lock >= 0)          g = act[lock] ? lock : -1;
      else if (act[0] && act[1])   g = RR ? (1 - last) : 1;
      else if (act[1])             g = 1;
      else if (act[0])             g = 0;
      else                         g = -1;
      e_addr  = (g >= 0) ? ra[g[0]] : '0;
      e_wdata = (g >= 0) ? rw[g[0]] : '0;
      e_wstrb = (g >= 0) ? rs[g[0]] : '0;

      chk("rnd m_avalid", m_avalid_o, (g >= 0));
      chk("rnd m_addr", m_addr_o, e_addr);
      chk("rnd m_wdata", m_wdata_o, e_wdata);
      chk("rnd m_wstrb", m_wstrb_o, e_wstrb);
      chk("rnd ibus_ready", ibus_ready_o, (g == 0) && m_ready_i);
      chk("rnd dbus_ready", dbus_ready_o, (g == 1) && m_ready_i);
      chk("rnd ibus_rvalid", ibus_rvalid_o, (rd == 0) && m_rvalid_i);
      chk("rnd dbus_rvalid", dbus_rvalid_o, (rd == 1) && m_rvalid_i);
      if (rd == 0 && m_rvalid_i) chk("rnd ibus_rdata", ibus_rdata_o, m_rdata_i);
      if (rd == 1 && m_rvalid_i) chk("rnd dbus_rdata", dbus_rdata_o, m_rdata_i);

      // model update
      if (rd >= 0) begin
        if (m_rvalid_i) rd = -1;
      end else if (g >= 0) begin
        if (m_ready_i) begin
          lock = -1;
          last = g;
          if (rs[g[0]] == '0) rd = g;
        end else begin
          lock = g;
        end
      end else begin
        lock = -1;
      end

      // masters react to what the DUT presented
      if (ibus_ready_o) begin act[0] = 1'b0; if (rs[0] == '0) wt[0] = 1'b1; end
      if (dbus_ready_o) begin act[1] = 1'b0; if (rs[1] == '0) wt[1] = 1'b1; end
      if (ibus_rvalid_o) wt[0] = 1'b0;
      if (dbus_rvalid_o) wt[1] = 1'b0;

      // slave bookkeeping
      if (pend && cnt == 0 && m_rvalid_i) pend = 1'b0;
      else if (pend && cnt > 0)           cnt--;
      if (m_avalid_o && m_ready_i && m_wstrb_o == '0) begin
        pend = 1'b1;
        cnt  = $urandom_range(0, 2);
      end
      cyc();
    end
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_picorv32_bus_merge.md
Name: iob_picorv32_bus_merge

Overview:
- Downstream stage of the PicoRV32 wrapper.
- Merges its separate instruction (ibus) and data (dbus) IOb-native master buses into one IOb-native master port, for single-port memories and single-port interconnects.
- Arbitrates between the two buses, locks the grant through the address phase, and tracks one outstanding read.
- Routes each read response back to the bus that issued the read.

Parameters:
- ADDR_W, 32, address width on all three buses.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- ibus_avalid_i  in  1  instruction request valid
- ibus_addr_i  in  ADDR_W  instruction address
- ibus_wdata_i  in  DATA_W  instruction write data (unused by core, still forwarded)
- ibus_wstrb_i  in  DATA_W/8  instruction write strobe
- ibus_rdata_o  out  DATA_W  instruction read data
- ibus_rvalid_o  out  1  instruction read data valid
- ibus_ready_o  out  1  instruction request accepted
- dbus_avalid_i / dbus_addr_i / dbus_wdata_i / dbus_wstrb_i  in  1/ADDR_W/DATA_W/DATA_W/8  data request
- dbus_rdata_o / dbus_rvalid_o / dbus_ready_o  out  DATA_W/1/1  data response
- m_avalid_o / m_addr_o / m_wdata_o / m_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  merged request
- m_rdata_i / m_rvalid_i / m_ready_i  in  DATA_W/1/1  merged response

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high. All state updates on the rising edge of clk_i.
- Reset state:
  - state=IDLE, sel=IBUS, last_winner=DBUS.
  - All outputs go to 0 combinationally once state=IDLE and no request is pending.
- Protocol:
  - A request is accepted in the cycle avalid&ready.
  - A write is a request with |wstrb!=0. It completes on acceptance and produces no rvalid.
  - A read returns rvalid at least 1 cycle after acceptance.
- IDLE state:
  - Winner = arbitrated among the asserted avalids.
  - m_* is driven from the winner in the same cycle (0-cycle forwarding).
  - If m_ready_i=1 that cycle: write -> stay IDLE; read -> WAIT_R with sel=winner.
  - If m_ready_i=0 that cycle: go to HOLD with sel=winner.
- HOLD state:
  - m_* is driven from sel; the grant is locked and the other bus is ignored.
  - On m_ready_i: write -> IDLE; read -> WAIT_R.
  - If the granted avalid drops before acceptance (protocol violation tolerance): go to IDLE.
- WAIT_R state:
  - m_avalid_o=0; both ready outputs are 0.
  - On m_rvalid_i: assert <sel>_rvalid_o=1 for that cycle with <sel>_rdata_o=m_rdata_i, then go to IDLE.
  - No new arbitration in the rvalid cycle, so there is 1 bubble between back-to-back reads.
- Output routing:
  - <x>_ready_o = m_ready_i & (current winner/sel == x) & (state != WAIT_R).
  - The non-selected bus sees ready=0 and rvalid=0.
  - rdata is driven to both buses; qualify it with rvalid.
- Arbitration:
  - Fixed priority: dbus wins over ibus.
  - The feature below changes this policy.
- Simultaneous events:
  - m_rvalid_i arriving in IDLE or HOLD is a slave error. Drop it; no master sees it.
  - Reset in WAIT_R discards the pending read; a late rvalid is dropped per the rule above.
- No counters wrap; all state is bounded.

Optional Feature:
- Macro: IOB_PICORV32_BUS_MERGE_RR_EN.
- When defined:
  - Round-robin arbitration: on a tie, the bus that is not last_winner wins.
  - last_winner updates on every accepted request.
- When undefined:
  - Fixed dbus priority; the last_winner register is not generated.
- Either way, grant locking in HOLD is unchanged.

Decomposition:
- Package iob_picorv32_bus_merge_pkg:
  - State encoding localparams IDLE=2'd0, HOLD=2'd1, WAIT_R=2'd2.
  - Select constants SEL_IBUS=1'b0, SEL_DBUS=1'b1.
- Sub-module iob_picorv32_bus_merge_arb:
  - 2-way combinational winner logic.
  - Holds the optional last_winner register.
  - Inputs: both avalids and the accept strobe. Output: winner.

Test Plan:
- ibus read, addr 0x1000_0000, m_ready_i=1 same cycle, m_rvalid_i 2 cycles later with rdata 0xDEAD_BEEF -> ibus_ready_o=1 in cycle 0; ibus_rvalid_o=1 with 0xDEAD_BEEF in cycle 2; dbus_rvalid_o=0 throughout.
- dbus write, addr 0x20, wdata 0x1234_5678, wstrb 4'hF, m_ready_i held 0 for 3 cycles then 1 -> m_* stable for 4 cycles; dbus_ready_o=1 only in cycle 3; no rvalid; state returns to IDLE.
- ibus and dbus reads asserted together, fixed priority -> dbus is served first. Then ibus is served after dbus_rvalid_o plus 1 bubble cycle.
- Same as the previous case with IOB_PICORV32_BUS_MERGE_RR_EN, 4 back-to-back contended reads -> grant order dbus, ibus, dbus, ibus.
- dbus enters HOLD, then ibus_avalid_i rises while m_ready_i=0 -> ibus_ready_o stays 0 and m_addr_o stays on the dbus address until dbus is accepted.
- Read accepted, rst_i=1 in WAIT_R, m_rvalid_i arrives the cycle after reset deasserts -> both rvalid outputs stay 0; state=IDLE.
